// File: rtl/uart_pkg.sv
// Shared UART definitions: baud engine state encoding and standard divisors.
package uart_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } baud_state_t;

  // Default oversample ratio (ticks per bit).
  localparam int DEF_OVERSAMPLE = 8;

  // Fractional divisor width used by the standard divisor constants.
  localparam int BAUD_FRAC_W = 4;

  // Divisors for a 100 MHz clock with 8x oversampling, FRAC_W = 4.
  localparam int DIV_9600_OS8_INT    = 1302;
  localparam int DIV_9600_OS8_FRAC   = 1;
  localparam int DIV_115200_OS8_INT  = 108;
  localparam int DIV_115200_OS8_FRAC = 8;

endpackage

// File: rtl/uart_frac_div.sv
// Fractional clock divider: counts each oversample period and stretches it
// by one cycle whenever the fractional accumulator carried on the last tick.
module uart_frac_div
  import uart_pkg::*;
#(
  parameter int DIV_W  = 16,
  parameter int FRAC_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              adv,
  input  logic [DIV_W-1:0]  div_int,
  input  logic [FRAC_W-1:0] div_frac,
  output logic              tick
);

  logic [DIV_W-1:0]  cnt_r;
  logic [FRAC_W-1:0] acc_r;
  logic              carry_r;
  logic [DIV_W-1:0]  eff_int_s;
  logic [DIV_W-1:0]  last_s;
  logic [FRAC_W:0]   sum_s;

  // Clamp the divisor, derive the terminal count and the next accumulator value.
  always_comb begin
    eff_int_s = (div_int < DIV_W'(2)) ? DIV_W'(2) : div_int;
    // eff_int_s >= 2, so subtracting first keeps the +carry inside DIV_W bits.
    last_s    = eff_int_s - DIV_W'(1) + DIV_W'(carry_r);
    sum_s     = {1'b0, acc_r} + {1'b0, div_frac};
    tick      = adv && (cnt_r == last_s);
  end

  // Period counter and fractional accumulator; clear restarts from phase zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r   <= '0;
      acc_r   <= '0;
      carry_r <= 1'b0;
    end else if (clr) begin
      cnt_r   <= '0;
      acc_r   <= '0;
      carry_r <= 1'b0;
    end else if (tick) begin
      cnt_r   <= '0;
      acc_r   <= sum_s[FRAC_W-1:0];
      carry_r <= sum_s[FRAC_W];
    end else begin
      cnt_r   <= cnt_r + DIV_W'(1);
    end
  end

endmodule

// File: rtl/uart_baud_engine.sv
// UART baud engine: programmable fractional divisor producing oversample,
// bit and mid-bit ticks, with shadowed divisor updates and phase resync.
module uart_baud_engine
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = DEF_OVERSAMPLE,
  parameter int DIV_W      = 16,
  parameter int FRAC_W     = 4,
  parameter int DEF_INT    = 1302,
  parameter int DEF_FRAC   = 0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          en,
  input  logic                          resync,
  input  logic                          div_wr,
  input  logic [DIV_W-1:0]              div_int_in,
  input  logic [FRAC_W-1:0]             div_frac_in,
  output logic                          div_pending,
  output logic                          tick_os,
  output logic                          tick_1x,
  output logic                          tick_mid,
  output logic [$clog2(OVERSAMPLE)-1:0] phase
);

  localparam int PH_W = $clog2(OVERSAMPLE);

  baud_state_t       state_r;
  baud_state_t       state_s;
  logic              running_s;
  logic              clr_s;
  logic              adv_s;
  logic              tick_raw_s;
  logic              tick_1x_s;
  logic              tick_mid_s;
  logic              apply_s;
  logic [DIV_W-1:0]  act_int_r;
  logic [FRAC_W-1:0] act_frac_r;
  logic [DIV_W-1:0]  sh_int_r;
  logic [FRAC_W-1:0] sh_frac_r;
  logic [PH_W-1:0]   phase_r;

  // Run/idle state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next state follows the enable in both directions.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE:    state_s = en ? RUN : IDLE;
      RUN:     state_s = en ? RUN : IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Run qualification, tick decode and divisor apply condition.
  always_comb begin
    running_s  = (state_r == RUN) && en;
    clr_s      = !running_s || resync;
    adv_s      = !clr_s;
    tick_1x_s  = tick_raw_s && (phase_r == PH_W'(OVERSAMPLE - 1));
    tick_mid_s = tick_raw_s && (phase_r == PH_W'(OVERSAMPLE / 2 - 1));
    apply_s    = tick_1x_s || (state_r == IDLE) || resync;
  end

  uart_frac_div #(
    .DIV_W  (DIV_W),
    .FRAC_W (FRAC_W)
  ) u_frac_div (
    .clk      (clk),
    .rst      (rst),
    .clr      (clr_s),
    .adv      (adv_s),
    .div_int  (act_int_r),
    .div_frac (act_frac_r),
    .tick     (tick_raw_s)
  );

  // Shadow/active divisor pair: writes land in the shadow and move to the
  // active copy only on a bit boundary, while idle, or on resync.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      act_int_r   <= DIV_W'(DEF_INT);
      act_frac_r  <= FRAC_W'(DEF_FRAC);
      sh_int_r    <= DIV_W'(DEF_INT);
      sh_frac_r   <= FRAC_W'(DEF_FRAC);
      div_pending <= 1'b0;
    end else begin
      if (apply_s) begin
        act_int_r  <= sh_int_r;
        act_frac_r <= sh_frac_r;
      end
      if (div_wr) begin
        sh_int_r    <= div_int_in;
        sh_frac_r   <= div_frac_in;
        div_pending <= 1'b1;
      end else if (apply_s) begin
        div_pending <= 1'b0;
      end
    end
  end

  // Phase counter and registered tick outputs; phase output lags by a cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_r  <= '0;
      phase    <= '0;
      tick_os  <= 1'b0;
      tick_1x  <= 1'b0;
      tick_mid <= 1'b0;
    end else begin
      tick_os  <= tick_raw_s;
      tick_1x  <= tick_1x_s;
      tick_mid <= tick_mid_s;
      if (clr_s) begin
        phase_r <= '0;
        phase   <= '0;
      end else begin
        if (tick_raw_s) begin
          phase_r <= phase_r + PH_W'(1);
        end
        phase <= phase_r;
      end
    end
  end

endmodule

// File: doc/uart_baud_engine.md
# uart_baud_engine

Parametrised UART baud-rate engine, the successor to the fixed two-rate baud generator. It produces the oversample tick and the bit tick from a runtime-programmable divisor with a fractional part. Divisor updates are glitch-free and applied only on bit boundaries. A resync input lets the RX path re-phase the ticks to a start-bit edge, so that `tick_mid` lands at mid-bit. It sits between the register interface and the UART TX/RX FSMs.

## Interface
- `OVERSAMPLE`, 8: oversample ticks per bit; power of two, 4..16.
- `DIV_W`, 16: width of the integer divisor.
- `FRAC_W`, 4: width of the fractional divisor, in units of 1/2^FRAC_W cycle.
- `DEF_INT`, 1302: reset integer divisor (9600 baud, 100 MHz, OVERSAMPLE 8).
- `DEF_FRAC`, 0: reset fractional divisor.
- `clk`  in  1  single clock; all logic is rising-edge.
- `rst`  in  1  asynchronous, active-high reset.
- `en`  in  1  run enable; low means idle.
- `resync`  in  1  one-cycle pulse; restarts phase from zero.
- `div_wr`  in  1  one-cycle strobe; captures `div_int_in` and `div_frac_in` into the shadow register.
- `div_int_in`  in  DIV_W  new integer divisor.
- `div_frac_in`  in  FRAC_W  new fractional divisor.
- `div_pending`  out  1  high while the shadow value has not yet been applied.
- `tick_os`  out  1  oversample tick, one cycle wide.
- `tick_1x`  out  1  bit tick, one cycle wide.
- `tick_mid`  out  1  mid-bit tick, one cycle wide.
- `phase`  out  $clog2(OVERSAMPLE)  current oversample index.

## Operation
- **States.**
  - IDLE (`en`=0): counter, accumulator and phase are held at 0, and all ticks are 0.
  - IDLE→RUN when `en` is sampled high. RUN→IDLE when `en` is sampled low; this takes effect in the same cycle and any partial period is discarded.
- **Period length.**
  - Each oversample period is `div_int` cycles, plus 1 when the previous accumulator update carried.
  - Accumulator update on every `tick_os`: acc ← (acc + div_frac) mod 2^FRAC_W; the carry-out sets the length of the next period.
  - The first period after enable or resync is exactly `div_int` cycles, with acc = 0.
- **Divisor clamp.** An active `div_int` below 2 is treated as 2.
- **Counter width.** The counter is DIV_W bits and counts 0 to period−1. period−1 always fits in DIV_W bits, including the case div_int = 2^DIV_W−1 with a carry.
- **Phase and bit ticks.**
  - `phase` increments modulo OVERSAMPLE on each `tick_os`.
  - `tick_1x` is asserted in the same cycle as the `tick_os` that wraps `phase` from OVERSAMPLE−1 to 0.
  - `tick_mid` is asserted in the same cycle as the `tick_os` that moves `phase` to OVERSAMPLE/2.
- **Resync.**
  - Clears the counter, accumulator and phase. No tick is issued in the resync cycle.
  - If a tick was due in that same cycle, resync wins and the tick is suppressed.
- **Divisor update.**
  - `div_wr` loads the shadow register and sets `div_pending`.
  - The shadow is copied to the active divisor at the first of: a `tick_1x` cycle, any cycle in IDLE, or a `resync` cycle. `div_pending` clears in that same cycle.
  - `div_wr` while pending overwrites the shadow.
  - `div_wr` in the same cycle as an apply: the old shadow is applied, the new value is captured, and `div_pending` stays 1.

## Timing
- **Reset values.**
  - All outputs reset to 0.
  - Active divisor and shadow = DEF_INT/DEF_FRAC.
  - Counter, accumulator and phase = 0; state = IDLE.
- **First tick.** With `en` sampled high at edge k (or `resync` at edge k while running), the first `tick_os` is high in the cycle beginning at edge k+div_int.
- **Registered outputs.** All ticks are registered, so there is no combinational path from inputs to outputs. `phase` shows its post-increment value in the cycle after the tick.
- **Update latency.** A new divisor governs the period that starts immediately after the apply cycle.
- **Reset mid-operation.** Asynchronous reset forces all outputs to 0 immediately. No tick is emitted on reset release.

## Structure
- Shared package `uart_pkg` holds:
  - `baud_state_t` enum, with values IDLE and RUN.
  - Divisor constants at 100 MHz: DIV_9600_OS8 = 1302/frac 1, DIV_115200_OS8 = 108/frac 8, with FRAC_W 4.
  - Default OVERSAMPLE.
- One natural sub-module, `uart_frac_div`, containing:
  - the counter;
  - the accumulator;
  - the carry logic, producing the raw `tick_os`.
- The top level owns the shadow/apply logic, the phase counter and the 1x/mid decode.

## Test plan
- **Reset defaults.** Reset, then `en`=1 with defaults → `tick_os` every 1302 cycles and `tick_1x` every 10416 cycles; first `tick_os` 1302 cycles after `en`.
- **Fractional divisor.** `div_int` 54, `div_frac` 4, FRAC_W 4 → period sequence 54,54,54,54,55 then repeating 54,54,54,55; exactly 868 cycles across 16 ticks in steady state.
- **Mid-bit divisor write.**
  - Write 108/0 mid-bit while running at 1302 → `div_pending` stays high until the next `tick_1x`, then the following period is 108.
  - Second write before apply → only the second value takes effect.
- **Resync mid-bit.** Resync at an arbitrary cycle with div 1302, OVERSAMPLE 8 → `tick_mid` 5208 cycles later and `tick_1x` 10416 cycles later; resync coincident with a due tick → that tick is absent.
- **Clamp.** `div_int_in` = 0 or 1 → `tick_os` every 2 cycles.
- **Disable and reset.** `en` dropped mid-period → ticks stop the next cycle and `phase` = 0. Async reset mid-bit → outputs are 0 immediately and the defaults are restored.
